// File: rtl/axis_mash11_mod_pkg.sv
// Shared types, constants and helpers for the MASH 1-1 modulator.
// Optional dither: define AXIS_MASH_DITHER_EN to enable the LFSR carry-in.
package mash_pkg;

    typedef logic [1:0] mash_code_t;

    localparam int          CODE_OFFSET = 1;
    localparam logic [15:0] LFSR_SEED   = 16'hACE1;
    // Fibonacci taps at bits 16,14,13,11 (1-based) -> positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;

    // Tick counter width; never narrower than one bit so OSR=1 still elaborates.
    function automatic int cnt_width(input int osr);
        if (osr <= 2) begin
            return 1;
        end else begin
            return $clog2(osr);
        end
    endfunction

    // Next LFSR input bit: XOR of the tapped state bits.
    function automatic logic lfsr_feedback(input logic [15:0] state);
        return ^(state & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/axis_mash11_mod_stage.sv
// One first-order accumulator stage of the MASH 1-1 modulator.
// The sum output is the value the accumulator takes on the next enabled edge.
module mash_stage
    import mash_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_addend,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH:0]   w_sum_full;

    assign w_sum_full = {1'b0, r_acc} + {1'b0, i_addend} + {{WIDTH{1'b0}}, i_cin};
    assign o_sum      = w_sum_full[WIDTH-1:0];
    assign o_cout     = w_sum_full[WIDTH];

    // Accumulate modulo 2^WIDTH on every enabled cycle; carry leaves as o_cout.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc <= {WIDTH{1'b0}};
        end else if (i_en) begin
            r_acc <= w_sum_full[WIDTH-1:0];
        end else begin
            r_acc <= r_acc;
        end
    end

endmodule

// File: rtl/axis_mash11_mod.sv
// Second-order MASH 1-1 delta-sigma modulator, AXI-Stream sample in, 2-bit code out.
// Optional feature macro: AXIS_MASH_DITHER_EN (LFSR dither on the stage-1 carry-in).
module axis_mash11_mod
    import mash_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OSR   = 64
) (
    input  logic             aclk,
    input  logic             arst,
    input  logic [WIDTH-1:0] s_axis_data_tdata,
    input  logic             s_axis_data_tvalid,
    output logic             s_axis_data_tready,
    output mash_code_t       m_axis_data_tdata,
    output logic             m_axis_data_tvalid,
    output logic             underflow,
    input  logic             underflow_clr
);

    localparam int             CNT_W    = cnt_width(OSR);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);

    logic [WIDTH-1:0] r_x;
    logic [CNT_W-1:0] r_cnt;
    logic             r_active;
    logic             r_c2_prev;

    logic             w_tick;
    logic             w_wrap;
    logic             w_load;
    logic             w_d;
    logic [WIDTH-1:0] w_s1_sum;
    logic [WIDTH-1:0] w_s2_sum;
    logic             w_c1;
    logic             w_c2;
    logic [2:0]       w_code_wide;

    assign w_tick             = r_active;
    assign w_wrap             = (r_cnt == CNT_LAST);
    assign s_axis_data_tready = !r_active || w_wrap;
    assign w_load             = s_axis_data_tvalid && s_axis_data_tready;

`ifdef AXIS_MASH_DITHER_EN
    logic [15:0] r_lfsr;

    // Dither source: advances once per modulator tick, bit 0 feeds stage 1.
    always_ff @(posedge aclk) begin
        if (arst) begin
            r_lfsr <= LFSR_SEED;
        end else if (w_tick) begin
            r_lfsr <= {r_lfsr[14:0], lfsr_feedback(r_lfsr)};
        end else begin
            r_lfsr <= r_lfsr;
        end
    end

    assign w_d = r_lfsr[0];
`else
    assign w_d = 1'b0;
`endif

    mash_stage #(.WIDTH(WIDTH)) u_stage1 (
        .i_clk    (aclk),
        .i_rst    (arst),
        .i_en     (w_tick),
        .i_addend (r_x),
        .i_cin    (w_d),
        .o_sum    (w_s1_sum),
        .o_cout   (w_c1)
    );

    mash_stage #(.WIDTH(WIDTH)) u_stage2 (
        .i_clk    (aclk),
        .i_rst    (arst),
        .i_en     (w_tick),
        .i_addend (w_s1_sum),
        .i_cin    (1'b0),
        .o_sum    (w_s2_sum),
        .o_cout   (w_c2)
    );

    // y + 1 = c1 + c2 + 1 - c2_prev never goes negative, so unsigned 3-bit math is exact.
    assign w_code_wide = {2'b00, w_c1} + {2'b00, w_c2} + 3'(CODE_OFFSET) - {2'b00, r_c2_prev};

    // Sample capture, tick counter, noise-cancel history, output code and underflow flag.
    always_ff @(posedge aclk) begin
        if (arst) begin
            r_x                <= {WIDTH{1'b0}};
            r_cnt              <= {CNT_W{1'b0}};
            r_active           <= 1'b0;
            r_c2_prev          <= 1'b0;
            m_axis_data_tdata  <= 2'b00;
            m_axis_data_tvalid <= 1'b0;
            underflow          <= 1'b0;
        end else begin
            if (w_load) begin
                r_x      <= s_axis_data_tdata;
                r_active <= 1'b1;
            end
            if (w_tick) begin
                r_cnt              <= w_wrap ? {CNT_W{1'b0}} : r_cnt + CNT_W'(1);
                r_c2_prev          <= w_c2;
                m_axis_data_tdata  <= w_code_wide[1:0];
                m_axis_data_tvalid <= 1'b1;
            end
            // A missed sample slot outranks a same-cycle clear.
            if (w_tick && w_wrap && !s_axis_data_tvalid) begin
                underflow <= 1'b1;
            end else if (underflow_clr) begin
                underflow <= 1'b0;
            end
        end
    end

    // Stage-2 sum only feeds the internal accumulator.
    logic w_unused;
    assign w_unused = ^w_s2_sum;

endmodule

// File: tb/tb_axis_mash11_mod.sv
// Directed bench for axis_mash11_mod with OSR=4.
module tb_axis_mash11_mod;

    logic        aclk = 1'b0;
    logic        arst;
    logic [15:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [1:0]  m_tdata;
    logic        m_tvalid;
    logic        underflow;
    logic        underflow_clr;

    int n_vec  = 0;
    int n_fail = 0;

    logic [1:0] pat [4];

    axis_mash11_mod #(.WIDTH(16), .OSR(4)) dut (
        .aclk               (aclk),
        .arst               (arst),
        .s_axis_data_tdata  (s_tdata),
        .s_axis_data_tvalid (s_tvalid),
        .s_axis_data_tready (s_tready),
        .m_axis_data_tdata  (m_tdata),
        .m_axis_data_tvalid (m_tvalid),
        .underflow          (underflow),
        .underflow_clr      (underflow_clr)
    );

    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One reset cycle, then check the cleared state.
    task automatic do_reset();
        arst          = 1'b1;
        s_tvalid      = 1'b0;
        s_tdata       = 16'h0000;
        underflow_clr = 1'b0;
        step();
        check("rst_tdata", 32'(m_tdata), 32'd0);
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_tready", 32'(s_tready), 32'd1);
        arst = 1'b0;
    endtask

    // Present a sample while idle; returns one step after the handshake edge (k=0).
    task automatic start(input logic [15:0] x);
        s_tvalid = 1'b1;
        s_tdata  = x;
        check("tready_idle", 32'(s_tready), 32'd1);
        step();
    endtask

    // 16'h8000 constant: codes 1,2,2,1 repeating from the first valid code.
    task automatic run_pattern(input string tag);
        start(16'h8000);
        for (int k = 0; k < 13; k++) begin
            if (k == 0) begin
                check({tag, "_tvalid0"}, 32'(m_tvalid), 32'd0);
            end else begin
                check({tag, "_code"}, 32'(m_tdata), 32'(pat[(k - 1) % 4]));
            end
            step();
        end
    endtask

    initial begin
        int sum;
        int n_non1;
        pat[0] = 2'd1; pat[1] = 2'd2; pat[2] = 2'd2; pat[3] = 2'd1;
        arst = 1'b1; s_tvalid = 1'b0; s_tdata = 16'h0000; underflow_clr = 1'b0;
        step();
        do_reset();

`ifndef AXIS_MASH_DITHER_EN
        // x=0: constant code 1, tready every 4th cycle, tvalid two cycles after handshake.
        start(16'h0000);
        for (int k = 0; k < 12; k++) begin
            check("x0_tready", 32'(s_tready), 32'((k % 4) == 3));
            if (k == 0) begin
                check("x0_tvalid0", 32'(m_tvalid), 32'd0);
            end else begin
                check("x0_tvalid", 32'(m_tvalid), 32'd1);
                check("x0_code", 32'(m_tdata), 32'd1);
            end
            step();
        end

        // Mid-stream reset, then the half-scale pattern twice to show identical restart.
        do_reset();
        run_pattern("h8000_a");
        do_reset();
        run_pattern("h8000_b");

        // Underflow: miss the slot at k=3, clear at k=8, set+clear together at k=11.
        do_reset();
        start(16'h8000);
        for (int k = 0; k < 16; k++) begin
            check("uf_flag", 32'(underflow), 32'((k >= 4 && k <= 8) || k >= 12));
            check("uf_tready", 32'(s_tready), 32'((k % 4) == 3));
            if (k > 0) begin
                check("uf_code", 32'(m_tdata), 32'(pat[(k - 1) % 4]));
            end
            s_tvalid      = !(k == 3 || k == 11);
            underflow_clr = (k == 8 || k == 11);
            step();
        end
        s_tvalid      = 1'b1;
        underflow_clr = 1'b0;

        // Full-scale input: sum of (code-1) over 65536 ticks is 65535 or 65536.
        do_reset();
        start(16'hFFFF);
        sum = 0;
        for (int k = 1; k <= 65536; k++) begin
            step();
            sum += 32'(m_tdata);
        end
        check("ffff_sum_ok", 32'((sum - 65536) >= 65535 && (sum - 65536) <= 65536), 32'd1);
`else
        // Dither on, x=0: the code must leave the idle value 1 at some point.
        start(16'h0000);
        n_non1 = 0;
        for (int k = 1; k <= 65536; k++) begin
            step();
            if (m_tdata != 2'd1) n_non1++;
        end
        check("dither_nonconst", 32'(n_non1 > 0), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_mash11_mod.md
Name: axis_mash11_mod

Overview:
Second-order MASH 1-1 delta-sigma modulator that consumes 16-bit unsigned NCO samples over AXI-Stream and produces a 2-bit multi-level code for the DAC output driver. It sits directly downstream of the NCO and upstream of the DAC pin driver. Each input sample is held for OSR modulator ticks. The modulator runs every clock once primed.

Parameters:
WIDTH, 16, input sample and accumulator width (unsigned)
OSR, 64, modulator ticks per input sample; legal range ≥1

Ports:
aclk  input  1  clock
arst  input  1  reset; synchronous, active-high
s_axis_data_tdata  input  WIDTH  unsigned sample
s_axis_data_tvalid  input  1  sample valid
s_axis_data_tready  output  1  block accepts a sample this cycle
m_axis_data_tdata  output  2  modulator code = y+1, range 0..3
m_axis_data_tvalid  output  1  code valid; no tready, the DAC consumes every cycle
underflow  output  1  sticky flag: a sample was due and none was valid
underflow_clr  input  1  clears the underflow flag

Behaviour:
- Reset (arst=1 at a rising edge of aclk) clears acc1, acc2, c2_prev, x_reg, cnt, active, m_axis_data_tdata=0, m_axis_data_tvalid=0, underflow=0. Reset mid-operation takes effect that cycle and discards all state.
- s_axis_data_tready = !active || (cnt == OSR-1). Combinational from registers only.
- Handshake (tvalid && tready): x_reg <= tdata; active <= 1.
- Tick: every cycle with active=1. The tick uses the x_reg value from before any same-cycle load.
- Stage 1: s1 = acc1 + x_reg + d (WIDTH+1 bits); c1 = s1[WIDTH]; acc1 <= s1[WIDTH-1:0].
- Stage 2: s2 = acc2 + s1[WIDTH-1:0]; c2 = s2[WIDTH]; acc2 <= s2[WIDTH-1:0].
- Noise cancel: y = c1 + c2 − c2_prev, giving a signed value in {−1,0,1,2}; c2_prev <= c2.
- Output registered: m_axis_data_tdata <= y+1; m_axis_data_tvalid <= 1 from the cycle after the first tick; it stays 1 until reset.
- Latency: handshake at cycle N → first tick at N+1 → first code valid at N+2.
- Counter: cnt increments each tick and wraps from OSR-1 to 0. When OSR=1, cnt is a constant 0 and tready=1 while active.
- Wrap with no valid sample: x_reg holds, ticks continue, underflow <= 1.
- underflow_clr clears the flag. If set and clear occur in the same cycle, set wins.
- tvalid while tready=0: no effect. The sample is not consumed; upstream holds it per AXIS rules.
- d = 0 unless the optional feature is enabled.
- Accumulators wrap modulo 2^WIDTH. No saturation anywhere.

Optional Feature:
AXIS_MASH_DITHER_EN
- Defined: 16-bit Fibonacci LFSR, taps 16,14,13,11, seeded 16'hACE1 at reset, advancing once per tick. Its bit 0 is d, the stage-1 carry-in.
- Undefined: no LFSR logic; d=0. The output sequence is deterministic and exactly as specified in the Test Plan.

Decomposition:
- Package mash_pkg contains:
  - typedef logic [1:0] mash_code_t
  - localparam CODE_OFFSET=1
  - LFSR_SEED=16'hACE1 and the LFSR tap mask
  - function for the counter width: $clog2(OSR), minimum 1
- Sub-module mash_stage (WIDTH): one first-order accumulator. Inputs: addend, carry-in, enable. Outputs: sum and carry-out. The top level instantiates it twice.

Test Plan:
- Reset, then x=0, OSR=4: tready=1 before the first handshake. After the handshake, tready pulses every 4th cycle. Code is constant 1; tvalid rises exactly 2 cycles after the handshake.
- x=16'h8000 constant, feature off: codes repeat 1,2,2,1 starting with the first valid code. The mean is 1.5.
- x=16'hFFFF constant, 65536 ticks: the sum of (code−1) equals 65535 ±1. Codes 0 and 3 appear only as ±1 excursions.
- OSR=4, upstream withholds tvalid for one sample slot: underflow asserts the cycle after the missed wrap, x_reg holds, and codes continue. An underflow_clr pulse clears the flag. Simultaneous set and clear leaves underflow=1.
- Assert arst for 1 cycle mid-stream: the next cycle shows all outputs 0 and tready=1. After a new handshake, the sequence restarts identically to the post-reset run.
- Build with AXIS_MASH_DITHER_EN, x=0: codes are no longer constant 1. Over 65536 ticks the mean of (code−1) matches the LFSR ones-density (32768/65535) to within ±1 count.
